// File: rtl/floor_display_pkg.sv
// Shared types, segment patterns and helpers
// for the elevator floor indicator.
package floor_display_pkg;

  typedef logic [0:6] seg7_t;

  localparam seg7_t SEG_0     = 7'b1000000;
  localparam seg7_t SEG_1     = 7'b1111001;
  localparam seg7_t SEG_2     = 7'b0100100;
  localparam seg7_t SEG_3     = 7'b0110000;
  localparam seg7_t SEG_4     = 7'b0011001;
  localparam seg7_t SEG_5     = 7'b0010010;
  localparam seg7_t SEG_6     = 7'b0000010;
  localparam seg7_t SEG_7     = 7'b1111000;
  localparam seg7_t SEG_8     = 7'b0000000;
  localparam seg7_t SEG_9     = 7'b0010000;
  localparam seg7_t SEG_E     = 7'b0000110;
  localparam seg7_t SEG_BLANK = 7'b1111111;
  localparam seg7_t SEG_DASH  = 7'b0111111;
  localparam seg7_t SEG_UP    = 7'b1111110;
  localparam seg7_t SEG_DOWN  = 7'b1110111;

  typedef enum logic [1:0] {
    DIR_IDLE,
    DIR_UP,
    DIR_DOWN
  } dir_t;

  function automatic seg7_t digit_to_seg(
    input logic [3:0] d
  );
    seg7_t s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_E;
    endcase
    return s;
  endfunction

  function automatic seg7_t dir_to_seg(
    input dir_t d
  );
    seg7_t s;
    case (d)
      DIR_UP:   s = SEG_UP;
      DIR_DOWN: s = SEG_DOWN;
      default:  s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/floor_display_if.sv
// Floor/motion inputs and display outputs
// of the floor indicator.
interface floor_display_if #(
  parameter int NUM_FLOORS = 6
);
  import floor_display_pkg::*;

  logic [NUM_FLOORS-1:0] currentF;
  logic                  moving;
  seg7_t                 out1;
  seg7_t                 out0;
  seg7_t                 out_dir;
  logic                  err;

  modport master (
    output currentF,
    output moving,
    input  out1,
    input  out0,
    input  out_dir,
    input  err
  );

  modport slave (
    input  currentF,
    input  moving,
    output out1,
    output out0,
    output out_dir,
    output err
  );

endinterface

// File: rtl/floor_display_ctrl_blink_timer.sv
// Blink half-period counter and phase flop.
// phase is the value in effect after the coming edge.
module blink_timer #(
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic phase
);

  localparam int W = $clog2(BLINK_HALF);
  localparam logic [W-1:0] LAST = W'(BLINK_HALF - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_n;
  logic         on_q;
  logic         on_n;

  // count while enabled; idle forces phase on
  always_comb begin
    cnt_n = '0;
    on_n  = 1'b1;
    if (enable) begin
      if (cnt_q == LAST) begin
        cnt_n = '0;
        on_n  = ~on_q;
      end else begin
        cnt_n = cnt_q + 1'b1;
        on_n  = on_q;
      end
    end
  end

  // counter and phase state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      on_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_n;
      on_q  <= on_n;
    end
  end

  assign phase = on_n;

endmodule

// File: rtl/floor_display_ctrl.sv
// Elevator floor indicator: label, mezzanine
// marker, blink while moving, travel direction.
module floor_display_ctrl
  import floor_display_pkg::*;
#(
  parameter int                    NUM_FLOORS  = 6,
  parameter logic [NUM_FLOORS-1:0] MEZZ_MASK   = 'b010100,
  parameter int                    BLINK_HALF  = 25_000_000,
  parameter int                    IDLE_CYCLES = 100_000_000
) (
  input logic            clk,
  input logic            reset,
  floor_display_if.slave bus
);

  localparam int IW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
  localparam int CW = $clog2(IDLE_CYCLES);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);

  logic          phase;
  logic          valid;
  logic [IW-1:0] idx;
  logic [4:0]    label;
  logic [IW-1:0] prev_q;
  logic [IW-1:0] prev_n;
  logic [CW-1:0] idle_q;
  logic [CW-1:0] idle_n;
  dir_t          dir_q;
  dir_t          dir_n;
  seg7_t         out1_n;
  seg7_t         out0_n;

  blink_timer #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blink (
    .clk   (clk),
    .reset (reset),
    .enable(bus.moving),
    .phase (phase)
  );

  // one-hot decode and floor label popcount
  always_comb begin
    valid = ($countones(bus.currentF) == 1);
    idx   = '0;
    for (int k = 0; k < NUM_FLOORS; k++) begin
      if (bus.currentF[k]) idx = IW'(k);
    end
    label = '0;
    for (int k = 0; k < NUM_FLOORS; k++) begin
      if (k <= int'(idx) && !MEZZ_MASK[k]) begin
        label = label + 5'd1;
      end
    end
  end

  // direction tracking; frozen on malformed codes
  always_comb begin
    prev_n = prev_q;
    idle_n = idle_q;
    dir_n  = dir_q;
    if (valid) begin
      if (idx != prev_q) begin
        prev_n = idx;
        idle_n = '0;
        dir_n  = (idx > prev_q) ? DIR_UP : DIR_DOWN;
      end else if (idle_q != IDLE_LAST) begin
        idle_n = idle_q + 1'b1;
        if (idle_n == IDLE_LAST) dir_n = DIR_IDLE;
      end
    end
  end

  // label/marker digits with blink blanking
  always_comb begin
    out1_n = SEG_E;
    out0_n = SEG_BLANK;
    if (valid) begin
      out1_n = (label > 5'd9) ? SEG_E
                              : digit_to_seg(label[3:0]);
      if (MEZZ_MASK[idx]) out0_n = SEG_DASH;
    end
    if (!phase) begin
      out1_n = SEG_BLANK;
      out0_n = SEG_BLANK;
    end
  end

  // registered state and outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q      <= '0;
      idle_q      <= '0;
      dir_q       <= DIR_IDLE;
      bus.out1    <= SEG_1;
      bus.out0    <= SEG_BLANK;
      bus.out_dir <= SEG_BLANK;
      bus.err     <= 1'b0;
    end else begin
      prev_q      <= prev_n;
      idle_q      <= idle_n;
      dir_q       <= dir_n;
      bus.out1    <= out1_n;
      bus.out0    <= out0_n;
      bus.out_dir <= dir_to_seg(dir_n);
      bus.err     <= ~valid;
    end
  end

endmodule

// File: doc/floor_display_ctrl.md
Name: floor_display_ctrl

Overview:
Parametrised elevator floor indicator driving two active-low 7-segment digits plus a direction digit. It takes the one-hot current-floor vector from the elevator FSM and a moving flag. It renders the floor label, with a mezzanine marker where configured. It blinks the label while the car is moving, infers travel direction from successive floors, and flags malformed floor codes.

Parameters:
- NUM_FLOORS, 6, width of the one-hot floor vector; legal range 2..16.
- MEZZ_MASK, 6'b010100, bit i = 1 marks floor index i as a mezzanine; width NUM_FLOORS.
- BLINK_HALF, 25_000_000, clock cycles per blink half-period; must be ≥ 2.
- IDLE_CYCLES, 100_000_000, cycles with no floor change before the direction indicator clears; must be ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; all state is cleared immediately on assertion.
- currentF  in  NUM_FLOORS  one-hot current floor; bit i is floor index i.
- moving  in  1  car in motion.
- out1  out  [0:6]  label digit, active-low, out1[0]=g … out1[6]=a.
- out0  out  [0:6]  mezzanine-marker digit, same encoding.
- out_dir  out  [0:6]  direction digit, same encoding.
- err  out  1  malformed floor code.

Behaviour:
- Segment patterns are written MSB-first as gfedcba.
  - Digit patterns: 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Other patterns: E=0000110, BLANK=1111111, DASH=0111111 (mezzanine marker), UP=1111110 (segment a), DOWN=1110111 (segment d).
- All outputs are registered. Latency from a currentF or moving change to the outputs is one clk edge.
- Reset values:
  - out1=1, out0=BLANK, out_dir=BLANK, err=0.
  - prev_idx=0, blink counter=0, blink phase=ON, idle counter=0.
- Valid input means currentF has exactly one bit set, at index i.
- Label for index i = the number of non-mezzanine floors with index ≤ i.
  - out1 shows the label digit. A label > 9 shows E.
  - out0 = DASH if MEZZ_MASK[i], else BLANK.
- Invalid input (zero bits, or more than one bit set):
  - out1=E, out0=BLANK, err=1.
  - prev_idx, direction and the idle counter are frozen.
  - err clears on the first cycle a valid code is registered.
- Direction (valid input only):
  - i > prev_idx: dir=UP. i < prev_idx: dir=DOWN.
  - On a change, prev_idx←i and the idle counter is cleared.
  - i == prev_idx: the idle counter increments, saturating. On reaching IDLE_CYCLES-1, dir=BLANK.
  - The first valid floor after reset with i==0 leaves dir BLANK.
- Blink:
  - While moving=1, the blink counter counts 0..BLINK_HALF-1. On the terminal count it wraps to 0 and the phase toggles.
  - Phase OFF forces out1=BLANK and out0=BLANK. out_dir and err are unaffected.
  - A floor change does not reset the blink counter.
  - The first edge with moving=0 forces phase=ON and counter=0.
- Simultaneous events:
  - Invalid input during phase OFF: out1/out0 are BLANK and err=1.
  - A floor change on the same edge as the idle terminal count: the change wins and dir is updated.
- Reset mid-operation: outputs return to their reset values asynchronously, and counters restart from 0 after release.

Decomposition:
- Package floor_display_pkg holds:
  - a seg7_t typedef (logic [0:6]);
  - the SEG_* pattern constants above;
  - a dir_t enum {DIR_IDLE, DIR_UP, DIR_DOWN};
  - a function digit_to_seg(logic [3:0]) returning seg7_t (E for values > 9).
- One sub-module, blink_timer: BLINK_HALF counter plus phase flop, with an enable input (moving) and a phase output. It is instantiated once.
- Label computation (popcount of non-mezzanine floors at or below the index), one-hot decode and the direction/idle logic stay in the top module.

Test Plan:
All scenarios use NUM_FLOORS=6, MEZZ_MASK=6'b010100, BLINK_HALF=4, IDLE_CYCLES=8.
1. Hold reset 2 cycles, then release with currentF=000001 → out1=1111001, out0=1111111, out_dir=1111111, err=0. Assert reset asynchronously mid-cycle later → outputs return to these values before the next edge.
2. Sweep currentF through 000001, 000010, 000100, 001000, 010000, 100000 with moving=0 → out1/out0 = 1/BLANK, 2/BLANK, 2/DASH, 3/BLANK, 3/DASH, 4/BLANK, each one edge after its input. out_dir=UP from the second step onward.
3. Step from 100000 to 001000, then hold 8 cycles → out_dir=DOWN (1110111), then BLANK after the idle count. Returning to 100000 → out_dir=UP on the next edge.
4. Hold currentF=000010 and raise moving for 12 cycles → out1 alternates 2 / BLANK every 4 cycles, out_dir unchanged. Drop moving during an OFF phase → out1=0100100 on the next edge.
5. Drive currentF=000000, then 001100 → err=1, out1=0000110, dir frozen. Restore 001000 → err=0, out1=0110000 one edge later.
6. Change currentF 000001→000010 on the same edge as the idle terminal count → out_dir=UP, not BLANK.
